// File: rtl/local_var_ctrl.sv
// Local-variable sequencer: runs get/set/tee/frame_enter between the operand stack
// and the single-port variable memory, bounds-checking every access against the frame.
module local_var_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [IDX_WIDTH-1:0]  cmd_idx,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic                  pop_valid,
  input  logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_ready,
  output logic                  push_valid,
  output logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  err_oob
);

  localparam int unsigned SUM_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {OP_GET, OP_SET, OP_TEE, OP_ENTER} op_t;
  typedef enum logic [2:0] {IDLE, RD, PUSH, POP, WR} state_t;

  state_t                state_q, state_d;
  op_t                   op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] frame_base_q, frame_base_d;
  logic [IDX_WIDTH-1:0]  frame_len_q, frame_len_d;

  logic                  cmd_ready_d, pop_ready_d, push_valid_d, mem_we_d, err_oob_d;
  logic [DATA_WIDTH-1:0] push_data_d, mem_wr_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] idx_addr;
  logic [SUM_W-1:0]      frame_end;
  logic                  frame_fits;
  logic                  idx_in_frame;

  assign accept       = cmd_valid && cmd_ready;
  assign idx_addr     = frame_base_q + ADDR_WIDTH'(cmd_idx);
  // Frame end computed one bit wider so a base near the top cannot wrap past DEPTH.
  assign frame_end    = SUM_W'(cmd_base) + SUM_W'(cmd_idx);
  assign frame_fits   = frame_end <= SUM_W'(DEPTH);
  assign idx_in_frame = cmd_idx < frame_len_q;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= OP_GET;
      addr_q       <= '0;
      data_q       <= '0;
      frame_base_q <= '0;
      frame_len_q  <= '0;
      cmd_ready    <= 1'b0;
      pop_ready    <= 1'b0;
      push_valid   <= 1'b0;
      push_data    <= '0;
      mem_addr     <= '0;
      mem_we       <= 1'b0;
      mem_wr_data  <= '0;
      err_oob      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      frame_base_q <= frame_base_d;
      frame_len_q  <= frame_len_d;
      cmd_ready    <= cmd_ready_d;
      pop_ready    <= pop_ready_d;
      push_valid   <= push_valid_d;
      push_data    <= push_data_d;
      mem_addr     <= mem_addr_d;
      mem_we       <= mem_we_d;
      mem_wr_data  <= mem_wr_data_d;
      err_oob      <= err_oob_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    frame_base_d  = frame_base_q;
    frame_len_d   = frame_len_q;
    cmd_ready_d   = 1'b0;
    pop_ready_d   = 1'b0;
    push_valid_d  = 1'b0;
    push_data_d   = '0;
    mem_addr_d    = '0;
    mem_we_d      = 1'b0;
    mem_wr_data_d = '0;
    err_oob_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = op_t'(cmd_op);
          addr_d = idx_addr;
          if (op_t'(cmd_op) == OP_ENTER) begin
            if (frame_fits) begin
              frame_base_d = cmd_base;
              frame_len_d  = cmd_idx;
            end else begin
              err_oob_d = 1'b1;
            end
          end else if (!idx_in_frame) begin
            err_oob_d = 1'b1;
          end else if (op_t'(cmd_op) == OP_GET) begin
            state_d    = RD;
            mem_addr_d = idx_addr;
          end else begin
            state_d     = POP;
            pop_ready_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end
      RD: begin
        state_d      = PUSH;
        push_valid_d = 1'b1;
        push_data_d  = mem_rd_data;
      end
      PUSH: begin
        if (push_ready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          push_valid_d = 1'b1;
          push_data_d  = push_data;
        end
      end
      POP: begin
        if (pop_valid) begin
          state_d       = WR;
          data_d        = pop_data;
          mem_we_d      = 1'b1;
          mem_addr_d    = addr_q;
          mem_wr_data_d = pop_data;
        end else begin
          pop_ready_d = 1'b1;
        end
      end
      WR: begin
        if (op_q == OP_TEE) begin
          state_d      = PUSH;
          push_valid_d = 1'b1;
          push_data_d  = data_q;
        end else begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_local_var_ctrl.sv
// Bench for local_var_ctrl: behavioural variable memory plus write/push scoreboards.
module tb_local_var_ctrl;

  localparam logic [1:0] OP_GET = 2'b00, OP_SET = 2'b01, OP_TEE = 2'b10, OP_FE = 2'b11;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_idx = '0;
  logic [9:0]  cmd_base = '0;
  logic        pop_valid = 1'b0;
  logic [31:0] pop_data = '0;
  logic        pop_ready;
  logic        push_valid;
  logic [31:0] push_data;
  logic        push_ready = 1'b0;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        err_oob;

  logic [31:0] mem [1024];

  int checks = 0;
  int passed = 0;
  int n_err = 0, n_wr = 0, n_pv = 0;
  wr_t         wq[$];
  logic [31:0] pq[$];

  local_var_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_base(cmd_base),
    .pop_valid(pop_valid), .pop_data(pop_data), .pop_ready(pop_ready),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wr_data;

  // Scoreboard: every memory write and every accepted push must match the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_oob) n_err++;
      if (push_valid) n_pv++;
      if (mem_we) begin
        wr_t w;
        n_wr++;
        checks++;
        if (wq.size() == 0) begin
          $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_wr_data);
        end else begin
          w = wq.pop_front();
          if (mem_addr !== w.addr || mem_wr_data !== w.data)
            $display("FAIL write addr=%0d data=%h required addr=%0d data=%h", mem_addr, mem_wr_data, w.addr, w.data);
          else passed++;
        end
      end
      if (push_valid && push_ready) begin
        logic [31:0] d;
        checks++;
        if (pq.size() == 0) begin
          $display("FAIL unexpected_push data=%h", push_data);
        end else begin
          d = pq.pop_front();
          if (push_data !== d) $display("FAIL push data=%h required %h", push_data, d);
          else passed++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 40) begin step(); n++; end
    if (n >= 40) begin
      checks++;
      $display("FAIL %s_timeout cmd_ready=%b required 1", tag, cmd_ready);
    end
  endtask

  // Offer one command and return #1 after the edge that accepts it.
  task automatic issue(input logic [1:0] op, input logic [7:0] idx, input logic [9:0] base);
    wait_ready("issue");
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_base = base;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #12;
    checks++;
    if ({cmd_ready, pop_ready, push_valid, mem_we, err_oob} !== 5'b0)
      $display("FAIL reset_ctrl got=%b required 00000", {cmd_ready, pop_ready, push_valid, mem_we, err_oob});
    else passed++;
    checks++;
    if ({mem_addr, mem_wr_data, push_data} !== '0)
      $display("FAIL reset_data addr=%0d wr=%h push=%h required 0", mem_addr, mem_wr_data, push_data);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) $display("FAIL ready_before_edge got=%b required 0", cmd_ready); else passed++;
    step();
    checks++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_after_edge got=%b required 1", cmd_ready); else passed++;
  endtask

  task automatic test_set_get();
    int wr0;
    issue(OP_FE, 8'd4, 10'd100);
    checks++;
    if (err_oob !== 1'b0 || cmd_ready !== 1'b0)
      $display("FAIL enter_ok err=%b ready=%b required 0 0", err_oob, cmd_ready);
    else passed++;
    wr0 = n_wr;
    pop_valid = 1'b1; pop_data = 32'hDEAD_BEEF;
    wq.push_back('{addr: 10'd102, data: 32'hDEAD_BEEF});
    issue(OP_SET, 8'd2, 10'd0);
    checks++;
    if (pop_ready !== 1'b1 || mem_we !== 1'b0) $display("FAIL set_pop pop_ready=%b we=%b required 1 0", pop_ready, mem_we); else passed++;
    step();
    pop_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 10'd102) $display("FAIL set_wr we=%b addr=%0d required 1 102", mem_we, mem_addr); else passed++;
    step();
    checks++;
    if (mem_we !== 1'b0 || cmd_ready !== 1'b1 || n_wr - wr0 != 1)
      $display("FAIL set_done we=%b ready=%b writes=%0d required 0 1 1", mem_we, cmd_ready, n_wr - wr0);
    else passed++;
    pop_valid = 1'b1; pop_data = 32'h1234_5678;
    wq.push_back('{addr: 10'd100, data: 32'h1234_5678});
    issue(OP_SET, 8'd0, 10'd0);
    step();
    pop_valid = 1'b0;
    wait_ready("set0");
    push_ready = 1'b1;
    pq.push_back(32'hDEAD_BEEF);
    issue(OP_GET, 8'd2, 10'd0);
    checks++;
    if (push_valid !== 1'b0 || mem_addr !== 10'd102) $display("FAIL get_rd pv=%b addr=%0d required 0 102", push_valid, mem_addr); else passed++;
    step();
    checks++;
    if (push_valid !== 1'b1 || push_data !== 32'hDEAD_BEEF) $display("FAIL get_push pv=%b data=%h required 1 deadbeef", push_valid, push_data); else passed++;
    step();
    checks++;
    if (push_valid !== 1'b0 || cmd_ready !== 1'b1 || pq.size() != 0 || wq.size() != 0)
      $display("FAIL get_done pv=%b ready=%b pq=%0d wq=%0d required 0 1 0 0", push_valid, cmd_ready, pq.size(), wq.size());
    else passed++;
  endtask

  task automatic test_oob();
    int e0 = n_err, pv0 = n_pv, wr0 = n_wr;
    issue(OP_GET, 8'd4, 10'd0);
    checks++;
    if ({err_oob, cmd_ready, mem_we, push_valid} !== 4'b1000)
      $display("FAIL oob_pulse got=%b required 1000", {err_oob, cmd_ready, mem_we, push_valid});
    else passed++;
    step();
    checks++;
    if (err_oob !== 1'b0 || cmd_ready !== 1'b1 || n_err - e0 != 1 || n_pv != pv0 || n_wr != wr0)
      $display("FAIL oob_after err=%b ready=%b errs=%0d pushes=%0d writes=%0d required 0 1 1 0 0",
               err_oob, cmd_ready, n_err - e0, n_pv - pv0, n_wr - wr0);
    else passed++;
  endtask

  task automatic test_bad_frame();
    int e0 = n_err;
    issue(OP_FE, 8'd8, 10'd1020);
    checks++;
    if (err_oob !== 1'b1) $display("FAIL enter_oob err=%b required 1", err_oob); else passed++;
    pq.push_back(32'h1234_5678);
    issue(OP_GET, 8'd0, 10'd0);
    checks++;
    if (mem_addr !== 10'd100) $display("FAIL old_frame addr=%0d required 100", mem_addr); else passed++;
    wait_ready("get0");
    issue(OP_FE, 8'd4, 10'd1020);
    checks++;
    if (err_oob !== 1'b0) $display("FAIL enter_edge err=%b required 0", err_oob); else passed++;
    pop_valid = 1'b1; pop_data = 32'hCAFE_0003;
    wq.push_back('{addr: 10'd1023, data: 32'hCAFE_0003});
    issue(OP_SET, 8'd3, 10'd0);
    step();
    pop_valid = 1'b0;
    pq.push_back(32'hCAFE_0003);
    issue(OP_GET, 8'd3, 10'd0);
    wait_ready("get_top");
    issue(OP_FE, 8'd4, 10'd100);
    wait_ready("restore");
    checks++;
    if (n_err - e0 != 1 || pq.size() != 0 || wq.size() != 0)
      $display("FAIL frame_tail errs=%0d pq=%0d wq=%0d required 1 0 0", n_err - e0, pq.size(), wq.size());
    else passed++;
  endtask

  task automatic test_tee_backpressure();
    push_ready = 1'b0;
    pop_valid = 1'b1; pop_data = 32'h5;
    wq.push_back('{addr: 10'd101, data: 32'h5});
    pq.push_back(32'h5);
    issue(OP_TEE, 8'd1, 10'd0);
    checks++;
    if (pop_ready !== 1'b1) $display("FAIL tee_pop pop_ready=%b required 1", pop_ready); else passed++;
    step();
    pop_valid = 1'b0;
    checks++;
    if ({pop_ready, mem_we, mem_addr} !== {1'b0, 1'b1, 10'd101})
      $display("FAIL tee_wr pop_ready=%b we=%b addr=%0d required 0 1 101", pop_ready, mem_we, mem_addr);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (push_valid !== 1'b1 || push_data !== 32'h5 || pop_ready !== 1'b0 || mem_we !== 1'b0)
        $display("FAIL tee_hold%0d pv=%b data=%h pr=%b we=%b required 1 5 0 0", i, push_valid, push_data, pop_ready, mem_we);
      else passed++;
    end
    push_ready = 1'b1;
    step();
    checks++;
    if (push_valid !== 1'b0 || cmd_ready !== 1'b1 || pq.size() != 0)
      $display("FAIL tee_done pv=%b ready=%b pq=%0d required 0 1 0", push_valid, cmd_ready, pq.size());
    else passed++;
  endtask

  task automatic test_pop_delay();
    int wr0 = n_wr;
    pop_valid = 1'b0; pop_data = 32'hFFFF_FFFF;
    wq.push_back('{addr: 10'd103, data: 32'hA5A5_0003});
    issue(OP_SET, 8'd3, 10'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (pop_ready !== 1'b1 || mem_we !== 1'b0) $display("FAIL pop_wait%0d pr=%b we=%b required 1 0", i, pop_ready, mem_we); else passed++;
      if (i < 2) step();
    end
    pop_valid = 1'b1; pop_data = 32'hA5A5_0003;
    step();
    pop_valid = 1'b0; pop_data = 32'h0;
    checks++;
    if (mem_we !== 1'b1 || pop_ready !== 1'b0 || mem_wr_data !== 32'hA5A5_0003)
      $display("FAIL pop_late we=%b pr=%b data=%h required 1 0 a5a50003", mem_we, pop_ready, mem_wr_data);
    else passed++;
    wait_ready("pop_delay");
    checks++;
    if (n_wr - wr0 != 1) $display("FAIL pop_writes got=%0d required 1", n_wr - wr0); else passed++;
  endtask

  task automatic test_reset_mid();
    int wr0 = n_wr, e0;
    pop_valid = 1'b0;
    issue(OP_SET, 8'd0, 10'd0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, pop_ready, push_valid, mem_we, err_oob, mem_addr} !== '0)
      $display("FAIL reset_mid got=%b required 0", {cmd_ready, pop_ready, push_valid, mem_we, err_oob, mem_addr});
    else passed++;
    pop_valid = 1'b1; pop_data = 32'h0BAD_0BAD;
    @(negedge clk);
    rst_n = 1'b1;
    pop_valid = 1'b0;
    step();
    checks++;
    if (n_wr != wr0 || cmd_ready !== 1'b1) $display("FAIL reset_nowrite writes=%0d ready=%b required 0 1", n_wr - wr0, cmd_ready); else passed++;
    e0 = n_err;
    issue(OP_GET, 8'd0, 10'd0);
    checks++;
    if (err_oob !== 1'b1 || push_valid !== 1'b0) $display("FAIL reset_frame err=%b pv=%b required 1 0", err_oob, push_valid); else passed++;
    step();
    checks++;
    if (n_err - e0 != 1 || cmd_ready !== 1'b1) $display("FAIL reset_frame_after errs=%0d ready=%b required 1 1", n_err - e0, cmd_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_set_get();
    test_oob();
    test_bad_frame();
    test_tee_backpressure();
    test_pop_delay();
    test_reset_mid();
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
